// File: rtl/result_misr.sv
// rtl/result_misr.sv - multiple-input signature register compacting a wide result bus
// Folds each accepted result into a SIG_W-bit chunk-XOR, then steps a Galois MISR.
module result_misr #(
    parameter int             Y_W   = 233,
    parameter int             SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Y_W-1:0]   y,
    input  logic             y_valid,
    input  logic             start,
    input  logic [7:0]       num_samples,
    input  logic [SIG_W-1:0] expected_sig,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [SIG_W-1:0] sig,
    output logic [7:0]       sample_cnt
);

    localparam int NCHUNK = (Y_W + SIG_W - 1) / SIG_W;
    localparam int EXT_W  = NCHUNK * SIG_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       target_q;
    logic [SIG_W-1:0] expected_q;
    logic [EXT_W-1:0] y_ext;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] misr_next;
    logic [7:0]       cnt_inc;

    assign y_ext = EXT_W'(y);

    always_comb begin
        fold = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            fold = fold ^ y_ext[i*SIG_W +: SIG_W];
        end
    end

    assign misr_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
    // Count never exceeds the latched target, so this cannot wrap.
    assign cnt_inc   = sample_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sig        <= '0;
            sample_cnt <= '0;
            target_q   <= '0;
            expected_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (start) begin
            sig        <= SEED;
            sample_cnt <= '0;
            target_q   <= num_samples;
            expected_q <= expected_sig;
            if (num_samples == 8'd0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                state <= CAPTURE;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else begin
            case (state)
                CAPTURE: begin
                    if (y_valid) begin
                        sig        <= misr_next;
                        sample_cnt <= cnt_inc;
                        if (cnt_inc == target_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign match = done && (sig == expected_q);

endmodule
